// File: rtl/ctrl_pipe_cond.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_cond
// Description : Control pipeline for the ARM-subset core. It registers the
//               decoded controls D->E and evaluates the condition code against
//               the NZCV register. It gates the side-effecting enables and
//               carries them through MEM_STAGES memory stages to writeback.
//               Optional feature macro: CTRL_SQUASH_CNT_EN (squash counter).
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_cond #(
    parameter int ALUCW      = 2,
    parameter int MEM_STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             MemtoRegD,
    input  logic             BranchD,
    input  logic             PCSD,
    input  logic [1:0]       FlagWD,
    input  logic [3:0]       CondD,
    input  logic [ALUCW-1:0] ALUControlD,
    input  logic [1:0]       ALUSrcD,
    input  logic             FlushE,
    input  logic [3:0]       ALUFlags,
    output logic [ALUCW-1:0] ALUControlE,
    output logic [1:0]       ALUSrcE,
    output logic             MemtoRegE,
    output logic             BranchTakenE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [3:0]       FlagsQ,
    output logic [15:0]      SquashCnt
);

    localparam logic [3:0] c_cond_al = 4'b1110;

    typedef struct packed {
        logic             regw;
        logic             memw;
        logic             mtr;
        logic             br;
        logic             pcs;
        logic [1:0]       flagw;
        logic [3:0]       cond;
        logic [ALUCW-1:0] aluc;
        logic [1:0]       alusrc;
    } e_ctrl_t;

    typedef struct packed {
        logic pcs;
        logic regw;
        logic memw;
        logic mtr;
    } m_ctrl_t;

    typedef struct packed {
        logic pcs;
        logic regw;
        logic mtr;
    } w_ctrl_t;

    e_ctrl_t    e_d, e_q;
    m_ctrl_t    m_d [MEM_STAGES];
    m_ctrl_t    m_q [MEM_STAGES];
    w_ctrl_t    w_d, w_q;
    logic [3:0] flags_d, flags_q;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ex;
    logic       w_regw_g, w_memw_g, w_pcs_g;

    assign {w_n, w_z, w_c, w_v} = flags_q;

    always_comb begin
        w_cond_ex = 1'b0;
        case (e_q.cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = !w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = !w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = !w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = !w_v;
            4'b1000: w_cond_ex = w_c & !w_z;
            4'b1001: w_cond_ex = !w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = !w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_regw_g = e_q.regw & w_cond_ex;
    assign w_memw_g = e_q.memw & w_cond_ex;
    assign w_pcs_g  = (e_q.pcs | e_q.br) & w_cond_ex;

    // A flushed slot becomes a bubble: no enables and an always-true condition.
    always_comb begin
        e_d      = '0;
        e_d.cond = c_cond_al;
        if (!FlushE) begin
            e_d.regw   = RegWriteD;
            e_d.memw   = MemWriteD;
            e_d.mtr    = MemtoRegD;
            e_d.br     = BranchD;
            e_d.pcs    = PCSD;
            e_d.flagw  = FlagWD;
            e_d.cond   = CondD;
            e_d.aluc   = ALUControlD;
            e_d.alusrc = ALUSrcD;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (e_q.flagw[1] && w_cond_ex) flags_d[3:2] = ALUFlags[3:2];
        if (e_q.flagw[0] && w_cond_ex) flags_d[1:0] = ALUFlags[1:0];
    end

    always_comb begin
        m_d[0].pcs  = w_pcs_g;
        m_d[0].regw = w_regw_g;
        m_d[0].memw = w_memw_g;
        m_d[0].mtr  = e_q.mtr;
        for (int i = 1; i < MEM_STAGES; i++) begin
            m_d[i] = m_q[i-1];
        end
        w_d.pcs  = m_q[MEM_STAGES-1].pcs;
        w_d.regw = m_q[MEM_STAGES-1].regw;
        w_d.mtr  = m_q[MEM_STAGES-1].mtr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q      <= '0;
            e_q.cond <= c_cond_al;
            flags_q  <= 4'b0000;
            for (int i = 0; i < MEM_STAGES; i++) begin
                m_q[i] <= '0;
            end
            w_q      <= '0;
        end else begin
            e_q     <= e_d;
            flags_q <= flags_d;
            for (int i = 0; i < MEM_STAGES; i++) begin
                m_q[i] <= m_d[i];
            end
            w_q     <= w_d;
        end
    end

`ifdef CTRL_SQUASH_CNT_EN
    logic [15:0] squash_cnt_d, squash_cnt_q;
    logic        w_e_live;

    assign w_e_live = e_q.regw | e_q.memw | e_q.br | e_q.pcs | (|e_q.flagw);

    always_comb begin
        squash_cnt_d = squash_cnt_q;
        if (w_e_live && !w_cond_ex && (squash_cnt_q != 16'hFFFF)) begin
            squash_cnt_d = squash_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_cnt_q <= 16'h0000;
        end else begin
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign SquashCnt = squash_cnt_q;
`else
    assign SquashCnt = 16'h0000;
`endif

    assign ALUControlE  = e_q.aluc;
    assign ALUSrcE      = e_q.alusrc;
    assign MemtoRegE    = e_q.mtr;
    assign BranchTakenE = w_pcs_g;
    assign RegWriteM    = m_q[0].regw;
    assign MemWriteM    = m_q[0].memw;
    assign PCSrcW       = w_q.pcs;
    assign RegWriteW    = w_q.regw;
    assign MemtoRegW    = w_q.mtr;
    assign FlagsQ       = flags_q;

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_cond.md
Name: ctrl_pipe_cond

Overview:
- Parametrised control pipeline for the pipelined ARM-subset core.
- Takes combinational decoder outputs in Decode and registers them D->E.
- Evaluates the condition field against an architectural NZCV flag register in Execute, then gates the side-effecting enables.
- Carries control through MEM_STAGES Memory stages to Writeback. Adds flush handling, partial flag writes, and multi-cycle memory latency.

Parameters:
- ALUCW, 2, width of the ALU control field.
- MEM_STAGES, 1, number of Memory pipeline stages between E and W; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- RegWriteD  in  1  decoded register write.
- MemWriteD  in  1  decoded memory write.
- MemtoRegD  in  1  writeback selects memory data.
- BranchD  in  1  instruction is a B.
- PCSD  in  1  instruction writes PC (Rd=15 data-processing or load).
- FlagWD  in  2  [1]=update NZ, [0]=update CV.
- CondD  in  4  Instr[31:28].
- ALUControlD  in  ALUCW  ALU operation.
- ALUSrcD  in  2  ALU operand select.
- FlushE  in  1  load a bubble into the E register at the next edge.
- ALUFlags  in  4  NZCV from the ALU in E.
- ALUControlE  out  ALUCW  registered ALU operation.
- ALUSrcE  out  2  registered operand select.
- MemtoRegE  out  1  for the hazard unit (load-use detect).
- BranchTakenE  out  1  (PCSE|BranchE) & CondExE; combinational.
- RegWriteM  out  1  first M stage, for the forwarding unit.
- MemWriteM  out  1  first M stage.
- PCSrcW  out  1  W stage.
- RegWriteW  out  1  W stage.
- MemtoRegW  out  1  W stage.
- FlagsQ  out  4  current NZCV register.
- SquashCnt  out  16  count of condition-failed instructions (see Optional Feature).

Behaviour:
- Reset (reset=0, async):
  - All pipeline registers clear to bubble: enables 0, CondE=4'b1110, ALUControlE=0, ALUSrcE=0.
  - FlagsQ=4'b0000.
  - All outputs 0.
- D->E register loads every rising edge. If FlushE=1 it loads a bubble instead; E is never stalled.
- CondExE is combinational from CondE and FlagsQ (N,Z,C,V):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 treated as never, 0.
- Gated E signals: RegW=RegWriteE&CondExE, MemW=MemWriteE&CondExE, PCS=(PCSE|BranchE)&CondExE. MemtoReg is not gated.
- Flag register:
  - FlagsQ[3:2]<=ALUFlags[3:2] when FlagWE[1]&CondExE.
  - FlagsQ[1:0]<=ALUFlags[1:0] when FlagWE[0]&CondExE.
  - Otherwise it holds.
  - A back-to-back dependent instruction in E on the next cycle sees the updated flags; no forwarding path is needed.
- M chain: stage M1 captures the gated signals and MemtoRegE; stages M2..M(MEM_STAGES) shift them unchanged. MemWriteM and RegWriteM come from M1 only.
- W register captures the last M stage.
- Latency D->W is MEM_STAGES+2 edges. Example: with MEM_STAGES=1, signals presented in D before edge 0 appear on the W outputs after edge 2.
- M and W stages advance every cycle and are unaffected by FlushE.
- FlushE asserted while the E instruction is a taken branch: the E instruction still moves to M1 at that edge; only the incoming D instruction is replaced by a bubble.
- reset asserted mid-operation clears every stage and the flags immediately; it does not wait for a clock edge.

Optional Feature:
- Macro: CTRL_SQUASH_CNT_EN.
- When defined: SquashCnt is a 16-bit counter.
  - Increments on each edge where E holds a non-bubble with CondExE=0.
  - Non-bubble means any of RegWriteE, MemWriteE, BranchE, PCSE, FlagWE is nonzero.
  - Saturates at 16'hFFFF; reset clears it to 0.
- When not defined: SquashCnt is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset: hold reset=0 while driving D inputs with enables=1 -> all outputs 0 and FlagsQ=0; release reset -> first W assertion after exactly MEM_STAGES+2 edges.
- Flag write then EQ: instruction A with FlagWD=11 while the E cycle has ALUFlags=0100 -> FlagsQ=0100. Next instruction B with CondD=0000 and RegWriteD=1 -> RegWriteM=1. Repeat with CondD=0001 -> RegWriteM=0.
- Partial flag write: FlagsQ=1111, then instruction with FlagWD=10 and ALUFlags=0000 -> FlagsQ=0011.
- Flush: a branch with CondD=1110 in E gives BranchTakenE=1. Assert FlushE in the same cycle with a store in D -> the store never produces MemWriteM=1; PCSrcW=1 after MEM_STAGES+1 further edges.
- MEM_STAGES=3: a single RegWriteD pulse -> RegWriteM is high at edge 2, RegWriteW is high at edge 5, each for one cycle.
- CTRL_SQUASH_CNT_EN: 3 instructions with CondD=1111 and 1 bubble -> SquashCnt=3. With the macro undefined -> SquashCnt=0.
